// File: rtl/skew_feeder_pkg.sv
// Shared definitions for the skew feeder: lane width, FSM state encoding and
// the drain counter width helper.
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

package skew_feeder_pkg;

  // Lane width, taken from the shared DATA_SIZE constant rather than a parameter.
  localparam int DATA_W = `DATA_SIZE;

  // Feeder control states; encoding is shared with the rest of the array.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width needed to hold ROWS+COLS-1 without ever wrapping below zero.
  function automatic int drain_cnt_w(input int rows, input int cols);
    return $clog2(rows + cols) + 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line for one feeder lane. DEPTH counts every
// register including the output register, so DEPTH=1 is a plain output flop.
module skew_delay_line
  import skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_stage [DEPTH];

  // Shift the lane entry value one stage per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is reset, not just the output, so that a reset
      // mid-burst cannot let stale data surface on the array edge later.
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's old value, giving a true shift instead of a flush-through.
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skew feeder: accepts activation vectors and presents lane r to the PE array
// r cycles later than lane 0, with a registered array enable and drain control.
// Optional feature: define SKEW_FEEDER_CNT_EN to add the vec_cnt beat counter.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int ROWS = 5,
  parameter int COLS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_last,
  output logic [ROWS*DATA_W-1:0] out_left,
  output logic                   go,
  output logic                   busy,
  output logic                   done
`ifdef SKEW_FEEDER_CNT_EN
  ,
  output logic [15:0]            vec_cnt
`endif
);

  localparam int                CNT_W      = drain_cnt_w(ROWS, COLS);
  localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(ROWS + COLS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [CNT_W-1:0]        r_drain_cnt;
  logic                    r_go;
  logic                    r_done;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_drain_exit;
  logic [ROWS*DATA_W-1:0]  w_entry;

  // Readiness depends only on the registered state, so accept has no loop.
  assign w_in_ready   = (r_state != DRAIN);
  assign w_accept     = in_valid && w_in_ready;
  assign w_drain_exit = (r_state == DRAIN) && (r_drain_cnt <= CNT_ONE);

  // Cycles without an accepted beat push zero bubbles into every lane.
  assign w_entry = w_accept ? in_data : '0;

  // Next-state decode for the IDLE / RUN / DRAIN controller.
  always_comb begin
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred for unlisted conditions.
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = in_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (w_accept && in_last) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_exit) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Drain counter: loads on DRAIN entry, counts down, and stops at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain_cnt <= '0;
    end else if ((r_state != DRAIN) && (w_next_state == DRAIN)) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if ((r_state == DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - CNT_ONE;
    end
  end

  // Registered enable and completion pulse, aligned with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_go   <= (w_next_state != IDLE);
      r_done <= w_drain_exit;
    end
  end

  // One delay line per lane; lane r is r+1 registers deep.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_delay_line #(
      .DEPTH(r + 1)
    ) u_line (
      .clk   (clk),
      .rst_n (rst),
      .i_data(w_entry[r*DATA_W +: DATA_W]),
      .o_data(out_left[r*DATA_W +: DATA_W])
    );
  end

  assign in_ready = w_in_ready;
  assign go       = r_go;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;

`ifdef SKEW_FEEDER_CNT_EN
  logic [15:0] r_vec_cnt;
  logic        w_enter_idle;

  assign w_enter_idle = (r_state != IDLE) && (w_next_state == IDLE);

  // Beats accepted in the current burst, cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec_cnt <= '0;
    end else if (w_enter_idle) begin
      r_vec_cnt <= '0;
    end else if (w_accept && (r_vec_cnt != 16'hFFFF)) begin
      r_vec_cnt <= r_vec_cnt + 16'd1;
    end
  end

  assign vec_cnt = r_vec_cnt;
`endif

endmodule
